main_core: RTL and testbench
============================

Name: main_core

Overview:
- Command-driven 64-bit streaming core.
- Host commands open bounded input or output transfers. Input words are written into an internal word FIFO; output words are drained from it, with optional per-word byte reversal.
- Sits between the host command/data channels and downstream processing. This scope covers the command decoder, input/output units and buffer.

Parameters:
- CMD_WHICH_SIZE, 3, width of destination-select field (the `MainCoreCMD_which_SIZE` define).
- CMD_SIZE, 17, width of command payload: {flag:1, size:16} (the `MainCoreCMD_SIZE` define).
- DEPTH, 16, buffer depth in 64-bit words (power of two).

Ports:
- clk  in  1  single clock, rising-edge.
- rst  in  1  reset; asynchronous, active-low.
- cmd  in  CMD_WHICH_SIZE+CMD_SIZE  {which, flag, size}; which in MSBs.
- cmd_hasAny  in  1  cmd valid.
- cmd_consume  out  1  cmd accepted this cycle.
- in  in  64  input data word.
- in_isReady  in  1  input word valid.
- in_canReceive  out  1  core accepts input word.
- out  out  64  output data word.
- out_isReady  out  1  output word valid.
- out_canReceive  in  1  host accepts output word.

Behaviour:
- Reset (rst low, async): buffer empty (read ptr = write ptr = 0, count 0); both units idle; remaining counts 0; swap flags 0. All handshake outputs 0; out = 0.
- Command decode by which:
  - which=0 (o_in): load input unit: remaining=size, swapIn=flag.
  - which=1 (o_out): load output unit: remaining=size, swapOut=flag.
  - any other which: consumed and ignored.
- cmd_consume is combinational: cmd_hasAny AND (target unit idle). For ignored codes it is simply cmd_hasAny.
- A command takes effect at the rising edge where cmd_hasAny & cmd_consume. Commands are strictly in order: a blocked command stalls all later ones.
- Unit idle means remaining==0. A size of 0 is consumed and leaves the unit idle.
- Input unit:
  - in_canReceive = (remaining!=0) & (count<DEPTH).
  - On an edge with in_isReady & in_canReceive: write the word (bytes reversed if swapIn: byte k → byte 7-k), increment write ptr, decrement remaining.
  - in_isReady without in_canReceive is ignored; no word is written.
- Output unit:
  - out_isReady = (remaining!=0) & (count!=0).
  - out = buffer[read ptr], byte-reversed if swapOut; combinational from buffer head. out = 0 when out_isReady is low.
  - On an edge with out_isReady & out_canReceive: increment read ptr, decrement remaining.
- Units run concurrently. A write and a read on the same edge leave count unchanged. A write to a full buffer is impossible, because in_canReceive is low when count==DEPTH.
- Pointers wrap modulo DEPTH. count is a DEPTH+1-valued counter.
- A new o_in/o_out command is accepted the same cycle the unit's last word transfers only if remaining==0 before that edge. Otherwise it is accepted on the next cycle (no same-edge reload).
- Reset mid-transfer aborts both units and discards buffer contents.
- No latency beyond one edge: a word written at edge N is readable (out_isReady) after edge N.

Test Plan:
- Reset: pulse rst low. Then in_canReceive=0, out_isReady=0, cmd_consume=0 with cmd_hasAny=0, out=0.
- Loopback: o_in size=2 flag=0, send 64'h0011223344556677 then 64'h8899AABBCCDDEEFF. Then o_out size=2 flag=0 receives both words unchanged, in order. After the last word, out_isReady=0 and in_canReceive=0.
- Byte swap: o_in size=1 flag=1 with 64'h0102030405060708, then o_out size=1 flag=0 → 64'h0807060504030201. Repeat with swap on output only → same result.
- Backpressure: o_in size=DEPTH+1, send 16 words. Then in_canReceive=0, since the buffer is full. Issue o_out size=1; receiving word 0 raises in_canReceive and the 17th word is accepted.
- Blocking: with the output unit busy (remaining>0, buffer empty), issue o_out. cmd_consume stays 0 and out_isReady stays 0 until the buffer is filled via a different path. An ignored which=7 command behind it is also stalled. After the unit drains, the pending command is consumed.
- Zero size and bad inputs:
  - o_in size=0 → consumed; in_canReceive stays 0.
  - in_isReady asserted without an open transfer is ignored; the buffer count is unchanged, checked by a subsequent o_out size=1 keeping out_isReady=0.

Source files
------------

// File: rtl/main_core.sv
// Command-driven 64-bit streaming core: a command decoder opens bounded input and
// output transfers that fill and drain a shared word FIFO, with optional byte reversal.
module main_core #(
  parameter int CMD_WHICH_SIZE = 3,
  parameter int CMD_SIZE       = 17,
  parameter int DEPTH          = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [CMD_WHICH_SIZE+CMD_SIZE-1:0] cmd,
  input  logic                               cmd_hasAny,
  output logic                               cmd_consume,
  input  logic [63:0]                        in,
  input  logic                               in_isReady,
  output logic                               in_canReceive,
  output logic [63:0]                        out,
  output logic                               out_isReady,
  input  logic                               out_canReceive
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = CMD_SIZE - 1;

  logic [CMD_WHICH_SIZE-1:0] which_s;
  logic                      flag_s;
  logic [SW-1:0]             size_s;
  logic                      in_load_s, out_load_s, wr_s, rd_s;

  logic [63:0]   mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [CW-1:0] count_r;
  logic [SW-1:0] in_rem_r, out_rem_r;
  logic          swap_in_r, swap_out_r;

  function automatic logic [63:0] byte_rev(input logic [63:0] w);
    logic [63:0] r;
    for (int k = 0; k < 8; k++) begin
      r[8*k +: 8] = w[8*(7-k) +: 8];
    end
    return r;
  endfunction

  assign which_s = cmd[CMD_WHICH_SIZE+CMD_SIZE-1 -: CMD_WHICH_SIZE];
  assign flag_s  = cmd[CMD_SIZE-1];
  assign size_s  = cmd[SW-1:0];

  // Command decode: a command is taken only when its target unit is idle.
  always_comb begin
    cmd_consume = 1'b0;
    in_load_s   = 1'b0;
    out_load_s  = 1'b0;
    case (which_s)
      CMD_WHICH_SIZE'(0): begin
        cmd_consume = cmd_hasAny & (in_rem_r == SW'(0));
        in_load_s   = cmd_consume;
      end
      CMD_WHICH_SIZE'(1): begin
        cmd_consume = cmd_hasAny & (out_rem_r == SW'(0));
        out_load_s  = cmd_consume;
      end
      default: cmd_consume = cmd_hasAny;
    endcase
  end

  // Handshakes and the buffer-head view presented to the host.
  always_comb begin
    in_canReceive = (in_rem_r != SW'(0)) & (count_r < CW'(DEPTH));
    out_isReady   = (out_rem_r != SW'(0)) & (count_r != CW'(0));
    wr_s          = in_isReady & in_canReceive;
    rd_s          = out_isReady & out_canReceive;
    if (out_isReady) begin
      out = swap_out_r ? byte_rev(mem_r[rd_ptr_r]) : mem_r[rd_ptr_r];
    end else begin
      out = 64'h0;
    end
  end

  // Buffer storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (wr_s) begin
      mem_r[wr_ptr_r] <= swap_in_r ? byte_rev(in) : in;
    end
  end

  // Unit state, pointers and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r   <= AW'(0);
      rd_ptr_r   <= AW'(0);
      count_r    <= CW'(0);
      in_rem_r   <= SW'(0);
      out_rem_r  <= SW'(0);
      swap_in_r  <= 1'b0;
      swap_out_r <= 1'b0;
    end else begin
      if (in_load_s) begin
        in_rem_r  <= size_s;
        swap_in_r <= flag_s;
      end else if (wr_s) begin
        in_rem_r <= in_rem_r - SW'(1);
      end
      if (out_load_s) begin
        out_rem_r  <= size_s;
        swap_out_r <= flag_s;
      end else if (rd_s) begin
        out_rem_r <= out_rem_r - SW'(1);
      end
      if (wr_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (rd_s) rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({wr_s, rd_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: tb/tb_main_core.sv
// Directed self-checking bench for main_core: loopback, byte swap, backpressure,
// command blocking, zero-size and stray-input cases, and mid-transfer reset.
module tb_main_core;

  logic        clk = 1'b0;
  logic        rst;
  logic [19:0] cmd;
  logic        cmd_hasAny, cmd_consume;
  logic [63:0] in, out;
  logic        in_isReady, in_canReceive, out_isReady, out_canReceive;

  int passed = 0;
  int total  = 0;

  main_core dut (
    .clk(clk), .rst(rst), .cmd(cmd), .cmd_hasAny(cmd_hasAny), .cmd_consume(cmd_consume),
    .in(in), .in_isReady(in_isReady), .in_canReceive(in_canReceive),
    .out(out), .out_isReady(out_isReady), .out_canReceive(out_canReceive)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Tasks start and end 1 time unit after a rising edge; checks sit 1 unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [2:0] w, input logic f, input logic [15:0] s);
    int n;
    cmd = {w, f, s};
    cmd_hasAny = 1'b1;
    #1;
    n = 0;
    while (!cmd_consume && n < 40) begin
      step();
      n++;
    end
    check("cmd_accept", {63'h0, cmd_consume}, 64'h1);
    step();
    cmd_hasAny = 1'b0;
  endtask

  task automatic push(input logic [63:0] w);
    in = w;
    in_isReady = 1'b1;
    #1;
    check("push_ready", {63'h0, in_canReceive}, 64'h1);
    step();
    in_isReady = 1'b0;
  endtask

  task automatic pop(input logic [63:0] exp);
    out_canReceive = 1'b1;
    #1;
    check("pop_valid", {63'h0, out_isReady}, 64'h1);
    check("pop_data", out, exp);
    step();
    out_canReceive = 1'b0;
  endtask

  initial begin
    rst = 1'b0; cmd = 20'h0; cmd_hasAny = 1'b0; in = 64'h0;
    in_isReady = 1'b0; out_canReceive = 1'b0;
    #12;
    check("rst_in_can", {63'h0, in_canReceive}, 64'h0);
    check("rst_out_rdy", {63'h0, out_isReady}, 64'h0);
    check("rst_consume", {63'h0, cmd_consume}, 64'h0);
    check("rst_out", out, 64'h0);
    step();
    rst = 1'b1;
    step();
    #1;
    check("post_rst_in_can", {63'h0, in_canReceive}, 64'h0);
    check("post_rst_out_rdy", {63'h0, out_isReady}, 64'h0);
    step();

    // Loopback
    send_cmd(3'd0, 1'b0, 16'd2);
    push(64'h0011223344556677);
    push(64'h8899AABBCCDDEEFF);
    send_cmd(3'd1, 1'b0, 16'd2);
    pop(64'h0011223344556677);
    pop(64'h8899AABBCCDDEEFF);
    #1;
    check("loop_out_rdy", {63'h0, out_isReady}, 64'h0);
    check("loop_in_can", {63'h0, in_canReceive}, 64'h0);
    step();

    // Byte swap on input, then on output
    send_cmd(3'd0, 1'b1, 16'd1);
    push(64'h0102030405060708);
    send_cmd(3'd1, 1'b0, 16'd1);
    pop(64'h0807060504030201);
    send_cmd(3'd0, 1'b0, 16'd1);
    push(64'h0102030405060708);
    send_cmd(3'd1, 1'b1, 16'd1);
    pop(64'h0807060504030201);

    // Backpressure: fill to DEPTH, stray write while full must be dropped
    send_cmd(3'd0, 1'b0, 16'd17);
    for (int i = 0; i < 16; i++) push(64'hA000_0000_0000_0000 + 64'(i));
    in = 64'hDEAD_DEAD_DEAD_DEAD;
    in_isReady = 1'b1;
    #1;
    check("full_in_can", {63'h0, in_canReceive}, 64'h0);
    step();
    in_isReady = 1'b0;
    send_cmd(3'd1, 1'b0, 16'd1);
    pop(64'hA000_0000_0000_0000);
    #1;
    check("unfull_in_can", {63'h0, in_canReceive}, 64'h1);
    step();
    push(64'hA000_0000_0000_0010);
    send_cmd(3'd1, 1'b0, 16'd16);
    for (int i = 1; i <= 16; i++) pop(64'hA000_0000_0000_0000 + 64'(i));

    // Blocking: output unit busy on an empty buffer stalls a second o_out
    send_cmd(3'd0, 1'b0, 16'd2);
    send_cmd(3'd1, 1'b0, 16'd2);
    cmd = {3'd1, 1'b0, 16'd1};
    cmd_hasAny = 1'b1;
    #1;
    check("blk_consume0", {63'h0, cmd_consume}, 64'h0);
    check("blk_out_rdy0", {63'h0, out_isReady}, 64'h0);
    step();
    step();
    check("blk_consume1", {63'h0, cmd_consume}, 64'h0);
    check("blk_out_rdy1", {63'h0, out_isReady}, 64'h0);
    push(64'h1111_2222_3333_4444);
    check("blk_consume2", {63'h0, cmd_consume}, 64'h0);
    pop(64'h1111_2222_3333_4444);
    push(64'h5555_6666_7777_8888);
    out_canReceive = 1'b1;
    #1;
    check("blk_last_consume", {63'h0, cmd_consume}, 64'h0);
    check("blk_last_data", out, 64'h5555_6666_7777_8888);
    step();
    out_canReceive = 1'b0;
    #1;
    check("blk_released", {63'h0, cmd_consume}, 64'h1);
    step();
    cmd_hasAny = 1'b0;
    send_cmd(3'd7, 1'b1, 16'hFFFF);
    send_cmd(3'd0, 1'b0, 16'd1);
    push(64'h0F0F_0F0F_0F0F_0F0F);
    pop(64'h0F0F_0F0F_0F0F_0F0F);

    // Zero size and stray input
    send_cmd(3'd0, 1'b0, 16'd0);
    #1;
    check("zero_in_can", {63'h0, in_canReceive}, 64'h0);
    step();
    in = 64'hBAD0_BAD0_BAD0_BAD0;
    in_isReady = 1'b1;
    step();
    step();
    in_isReady = 1'b0;
    send_cmd(3'd1, 1'b0, 16'd1);
    #1;
    check("stray_out_rdy0", {63'h0, out_isReady}, 64'h0);
    step();
    step();
    check("stray_out_rdy1", {63'h0, out_isReady}, 64'h0);

    // Mid-transfer reset aborts everything
    send_cmd(3'd0, 1'b0, 16'd3);
    push(64'h1234_5678_9ABC_DEF0);
    #1;
    check("pre_abort_rdy", {63'h0, out_isReady}, 64'h1);
    rst = 1'b0;
    #1;
    check("abort_out_rdy", {63'h0, out_isReady}, 64'h0);
    check("abort_out", out, 64'h0);
    check("abort_in_can", {63'h0, in_canReceive}, 64'h0);
    step();
    rst = 1'b1;
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
